mdu_unit: RTL

- Execute-stage multiply/divide unit for the 5-stage MIPS pipeline; owns the HI/LO registers.
- Consumes the E-stage MD operation and operands, including forwarded rs/rt after the ForwardAE/ForwardBE muxes.
- Produces StartE (start_o) and BusyE (busy_o), which the hazard unit uses to stall MD-using instructions in D.
- Supplies MFHI/MFLO read data to the E-stage result path.

---
 rtl/md_pkg.sv | 27 ++
 rtl/mdu_arith.sv | 57 +++++
 rtl/mdu_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared multiply/divide constants for the E-stage MD unit and the
// decoder (MDUseD uses the same opcodes).
//   md_op encodings : MD_NONE..MFLO (4 bits)
//   MD_IS_START()   : true for the ops that occupy the unit (MULT/MULTU/DIV/DIVU)
//   md_state_e      : MD unit FSM states
package md_pkg;

    localparam logic [3:0] MD_NONE = 4'd0;
    localparam logic [3:0] MULT    = 4'd1;
    localparam logic [3:0] MULTU   = 4'd2;
    localparam logic [3:0] DIV     = 4'd3;
    localparam logic [3:0] DIVU    = 4'd4;
    localparam logic [3:0] MTHI    = 4'd5;
    localparam logic [3:0] MTLO    = 4'd6;
    localparam logic [3:0] MFHI    = 4'd7;
    localparam logic [3:0] MFLO    = 4'd8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    function automatic logic MD_IS_START(input logic [3:0] op);
        return (op >= MULT) && (op <= DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit result for the MD unit.
//   op          in  4   md_op (md_pkg encoding)
//   a, b        in  32  rs / rt operands
//   result      out 64  {hi, lo}; product for MULT*, {remainder, quotient} for DIV*
//   div_by_zero out 1   DIV/DIVU with b == 0 (caller keeps HI/LO)
module mdu_arith
    import md_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] divisor_safe;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    // Low 64 bits of the product of sign-extended operands is the exact
    // signed 32x32 product.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // One unsigned divider serves both DIV and DIVU: signed operands are
    // converted to magnitudes and the signs restored afterwards. This also
    // yields 0x80000000 / -1 = 0x80000000 rem 0 without special casing,
    // since |0x80000000| is still representable as an unsigned value.
    assign signed_div   = (op == DIV);
    assign dividend     = (signed_div && a[31]) ? -a : a;
    assign divisor      = (signed_div && b[31]) ? -b : b;
    assign divisor_safe = (b == 32'd0) ? 32'd1 : divisor;
    assign quo_mag      = dividend / divisor_safe;
    assign rem_mag      = dividend % divisor_safe;
    assign quo          = (signed_div && (a[31] ^ b[31])) ? -quo_mag : quo_mag;
    assign rem          = (signed_div && a[31]) ? -rem_mag : rem_mag;

    assign div_by_zero  = ((op == DIV) || (op == DIVU)) && (b == 32'd0);

    always_comb begin
        result = 64'd0;
        case (op)
            MULT:      result = prod_s;
            MULTU:     result = prod_u;
            DIV, DIVU: result = {rem, quo};
            default:   result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: E-stage multiply/divide unit owning HI/LO.
//   clk, rst_n  in   clock (rising edge), async active-low reset
//   md_op       in   4   E-stage MD opcode
//   a_i, b_i    in   32  forwarded rs / rt operands
//   cancel_i    in   1   E-stage instruction killed; blocks start and MTHI/MTLO
//   start_o     out  1   MULT/MULTU/DIV/DIVU accepted this cycle (combinational)
//   busy_o      out  1   operation in flight (from state register)
//   hi_o, lo_o  out  32  architectural HI / LO
//   rd_data_o   out  32  MFHI/MFLO read data, 0 for other ops
// The result is computed in full on the start edge and parked in a pending
// register; the counter only models the pipeline-visible latency.
module mdu_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  md_op,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cancel_i,
    output logic        start_o,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] rd_data_o
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e        state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [63:0]      pending_reg;
    logic             pending_dz_reg;
    logic [31:0]      hi_reg, lo_reg;
    logic             finish;
    logic             is_div;
    logic [63:0]      arith_result;
    logic             arith_dz;

    mdu_arith u_arith (
        .op          (md_op),
        .a           (a_i),
        .b           (b_i),
        .result      (arith_result),
        .div_by_zero (arith_dz)
    );

    assign busy_o  = (state_reg == RUN);
    assign start_o = MD_IS_START(md_op) && !busy_o && !cancel_i;
    assign is_div  = (md_op == DIV) || (md_op == DIVU);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_o) begin
                    state_next = RUN;
                    count_next = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            RUN: begin
                // cancel_i is deliberately not looked at here: the op was
                // committed when it left E.
                if (count_reg == CNT_W'(1)) begin
                    state_next = IDLE;
                    count_next = '0;
                    finish     = 1'b1;
                end else begin
                    count_next = count_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            pending_reg    <= 64'd0;
            pending_dz_reg <= 1'b0;
            hi_reg         <= 32'd0;
            lo_reg         <= 32'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (start_o) begin
                pending_reg    <= arith_result;
                pending_dz_reg <= arith_dz;
            end
            if (finish) begin
                if (!pending_dz_reg) begin
                    hi_reg <= pending_reg[63:32];
                    lo_reg <= pending_reg[31:0];
                end
            end else if (!busy_o && !cancel_i) begin
                if (md_op == MTHI) hi_reg <= a_i;
                if (md_op == MTLO) lo_reg <= a_i;
            end
        end
    end

    assign hi_o = hi_reg;
    assign lo_o = lo_reg;

    always_comb begin
        rd_data_o = 32'd0;
        if (md_op == MFHI) rd_data_o = hi_reg;
        if (md_op == MFLO) rd_data_o = lo_reg;
    end

    // The hazard unit must stall MTHI/MTLO while an operation is in flight.
    mt_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(busy_o && ((md_op == MTHI) || (md_op == MTLO))));

endmodule
